byte_writer_arb: RTL and testbench

BYTE_WRITER_ARB -- requirements
Module: byte_writer_arb

---
 rtl/byte_writer_arb_pkg.sv | 26 ++
 rtl/byte_writer_arb_rr_arbiter.sv | 34 +++
 rtl/byte_writer_arb.sv | 213 +++++++++++++++++++++
 tb/tb_byte_writer_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_writer_arb_pkg.sv
// Shared types and constants for the byte-writer request arbiter.
// FSM state encoding, launch pulse length, default engine timeout, round-robin pointer helper.
package byte_writer_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int LAUNCH_CYC      = 2;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int MAX_REQ         = 8;
    localparam int IDX_W           = 3;

    // Pointer to the requester after idx, wrapping at n.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/byte_writer_arb_rr_arbiter.sv
// Round-robin one-hot grant: first requester at or after ptr, wrapping to index 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter
    import byte_writer_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        // Upper segment [ptr .. NUM_REQ-1] has priority over the wrapped segment.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (IDX_W'(j) >= ptr)) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_writer_arb.sv
// Arbitrates NUM_REQ write requesters onto one byte-writer engine; optional WAIT timeout via BYTE_WRITER_ARB_TIMEOUT_EN.
// Latency: request to rsp_valid is 6 cycles minimum (IDLE, GRANT, 2x LAUNCH, WAIT, RESP).
// Backpressure: requests stay pending until their one-cycle req_ready; only one transaction in flight.
module byte_writer_arb
    import byte_writer_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_strb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic                          M_INIT_AXI_TXN,
    output logic [ADDR_W-1:0]             M_TXN_ADDR,
    output logic [DATA_W-1:0]             M_TXN_DATA,
    output logic [(DATA_W/8)-1:0]         M_TXN_STRB,
    input  logic                          M_TXN_DONE,
    input  logic                          M_ERROR,
    output logic                          busy
);

    localparam int STRB_W = DATA_W / 8;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("byte_writer_arb: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [STRB_W-1:0]    strb_q, strb_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 init_q, init_d;
    logic                 busy_q, busy_d;
    logic [1:0]           launch_cnt_q, launch_cnt_d;
    logic                 done_prev_q, done_prev_d;

`ifdef BYTE_WRITER_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]     tmo_q, tmo_d;
`endif

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [ADDR_W-1:0]    addr_sel;
    logic [DATA_W-1:0]    data_sel;
    logic [STRB_W-1:0]    strb_sel;
    logic [NUM_REQ-1:0]   resp_oh;
    logic                 done_rise;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        addr_sel  = '0;
        data_sel  = '0;
        strb_sel  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                grant_idx = IDX_W'(j);
                addr_sel  = req_addr[j*ADDR_W +: ADDR_W];
                data_sel  = req_data[j*DATA_W +: DATA_W];
                strb_sel  = req_strb[j*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        resp_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            resp_oh[j] = (idx_q == IDX_W'(j));
        end
    end

    // A done level left over from before WAIT must drop and rise again to count.
    assign done_rise = M_TXN_DONE && !done_prev_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_err_d    = 1'b0;
        init_d       = 1'b0;
        launch_cnt_d = launch_cnt_q;
        done_prev_d  = M_TXN_DONE;
`ifdef BYTE_WRITER_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d     = ST_GRANT;
                    req_ready_d = grant;
                    idx_d       = grant_idx;
                    addr_d      = addr_sel;
                    data_d      = data_sel;
                    strb_d      = strb_sel;
                    ptr_d       = rr_next(grant_idx, NUM_REQ);
                end
            end
            ST_GRANT: begin
                state_d      = ST_LAUNCH;
                init_d       = 1'b1;
                launch_cnt_d = '0;
            end
            ST_LAUNCH: begin
                if (launch_cnt_q == 2'(LAUNCH_CYC - 1)) begin
                    state_d = ST_WAIT;
`ifdef BYTE_WRITER_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    launch_cnt_d = launch_cnt_q + 1'b1;
                    init_d       = 1'b1;
                end
            end
            ST_WAIT: begin
                if (done_rise) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = resp_oh;
                    rsp_err_d   = M_ERROR;
                end
`ifdef BYTE_WRITER_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = resp_oh;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            init_q       <= 1'b0;
            busy_q       <= 1'b0;
            launch_cnt_q <= '0;
            done_prev_q  <= 1'b0;
`ifdef BYTE_WRITER_ARB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            init_q       <= init_d;
            busy_q       <= busy_d;
            launch_cnt_q <= launch_cnt_d;
            done_prev_q  <= done_prev_d;
`ifdef BYTE_WRITER_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign M_INIT_AXI_TXN = init_q;
    assign M_TXN_ADDR     = addr_q;
    assign M_TXN_DATA     = data_q;
    assign M_TXN_STRB     = strb_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_byte_writer_arb.sv
// Directed scoreboard bench for byte_writer_arb: expected grants, launches and responses are queued by
// the stimulus and popped by an independent negedge monitor.
module tb_byte_writer_arb;

    localparam int NR  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    typedef struct { int idx; bit err; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; } txn_t;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR*SW-1:0]  req_strb;
    logic [NR-1:0]     rsp_valid;
    logic              rsp_err;
    logic              M_INIT_AXI_TXN;
    logic [AW-1:0]     M_TXN_ADDR;
    logic [DW-1:0]     M_TXN_DATA;
    logic [SW-1:0]     M_TXN_STRB;
    logic              M_TXN_DONE;
    logic              M_ERROR;
    logic              busy;

    logic [AW-1:0] addr_tab [NR] = '{32'h4000_0000, 32'h1000_0104, 32'h2000_0208, 32'h3000_030C};
    logic [DW-1:0] data_tab [NR] = '{32'hA5A5_A5A5, 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF};
    logic [SW-1:0] strb_tab [NR] = '{4'hF, 4'h3, 4'hC, 4'h5};

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = addr_tab[g];
        assign req_data[g*DW +: DW] = data_tab[g];
        assign req_strb[g*SW +: SW] = strb_tab[g];
    end

    byte_writer_arb #(
        .NUM_REQ     (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_strb       (req_strb),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .M_INIT_AXI_TXN (M_INIT_AXI_TXN),
        .M_TXN_ADDR     (M_TXN_ADDR),
        .M_TXN_DATA     (M_TXN_DATA),
        .M_TXN_STRB     (M_TXN_STRB),
        .M_TXN_DONE     (M_TXN_DONE),
        .M_ERROR        (M_ERROR),
        .busy           (busy)
    );

    always #5 ACLK = ~ACLK;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    rsp_t exp_rsp_q[$];
    txn_t exp_txn_q[$];
    int   exp_gnt_q[$];
    int   gnt_seen  = 0;
    int   rsp_seen  = 0;
    int   wait_seen = 0;
    int   rsp_cnt [NR];
    bit   lat_chk   = 1'b0;
    bit   tmo_chk   = 1'b0;
    int   t0        = 0;
    int   wait_start = 0;
    bit   eng_auto  = 1'b1;
    bit   eng_err   = 1'b0;
    int   eng_delay = 0;
    bit   auto_drop = 1'b1;

    logic [NR-1:0] ready_prev = '0;
    logic [NR-1:0] rsp_prev   = '0;
    logic          init_prev  = 1'b0;
    int            init_len   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge ACLK);
            if (exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0 && !busy) break;
        end
        if (k >= budget) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: still busy after %0d cycles, want idle", name, budget);
        end
    endtask

    task automatic wait_for_wait(input string name, input int w0);
        int k;
        for (k = 0; k < 50 && wait_seen == w0; k++) @(negedge ACLK);
        if (wait_seen == w0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: WAIT never entered within 50 cycles", name);
        end
    endtask

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // Monitor: pops expectations whenever the DUT presents a grant, launch or response.
    initial forever begin
        @(negedge ACLK);
        if (ARESET) begin
            init_len = 0;
        end else begin
            if (ready_prev != '0) chk("ready_one_cycle", 64'(req_ready), 64'(0));
            if (req_ready != '0) begin
                gnt_seen++;
                chk("ready_onehot", 64'($onehot(req_ready)), 64'(1));
                if (exp_gnt_q.size() == 0) chk("unexpected_grant", 64'(req_ready), 64'(0));
                else begin
                    int g;
                    g = exp_gnt_q.pop_front();
                    chk("grant_idx", 64'(req_ready), 64'(1) << g);
                end
            end
            if (M_INIT_AXI_TXN) init_len++;
            if (M_INIT_AXI_TXN && !init_prev) begin
                if (exp_txn_q.size() == 0) chk("unexpected_launch", 64'(M_INIT_AXI_TXN), 64'(0));
                else begin
                    txn_t t;
                    t = exp_txn_q.pop_front();
                    chk("txn_addr", 64'(M_TXN_ADDR), 64'(t.addr));
                    chk("txn_data", 64'(M_TXN_DATA), 64'(t.data));
                    chk("txn_strb", 64'(M_TXN_STRB), 64'(t.strb));
                end
            end
            if (!M_INIT_AXI_TXN && init_prev) begin
                chk("init_len", 64'(init_len), 64'(2));
                init_len   = 0;
                wait_start = cyc;
                wait_seen++;
            end
            if (rsp_prev != '0) chk("rsp_one_cycle", 64'(rsp_valid), 64'(0));
            if (rsp_valid != '0) begin
                rsp_seen++;
                for (int i = 0; i < NR; i++) if (rsp_valid[i]) rsp_cnt[i]++;
                if (exp_rsp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                else begin
                    rsp_t r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(1) << r.idx);
                    chk("rsp_err", 64'(rsp_err), 64'(r.err));
                    if (lat_chk) chk("latency", 64'(cyc - t0 + 1), 64'(6));
                    if (tmo_chk) chk("timeout_cycle", 64'(cyc - wait_start + 1), 64'(17));
                end
            end else if (rsp_err) begin
                chk("rsp_err_idle", 64'(rsp_err), 64'(0));
            end
        end
        ready_prev = req_ready;
        rsp_prev   = rsp_valid;
        init_prev  = M_INIT_AXI_TXN;
    end

    // Engine model: pulses done eng_delay cycles after the launch pulse ends.
    initial begin
        logic eng_init_prev;
        eng_init_prev = 1'b0;
        forever begin
            @(negedge ACLK);
            if (eng_auto && eng_init_prev && !M_INIT_AXI_TXN && !ARESET) begin
                repeat (eng_delay) @(negedge ACLK);
                M_TXN_DONE = 1'b1;
                M_ERROR    = eng_err;
                @(negedge ACLK);
                M_TXN_DONE = 1'b0;
                M_ERROR    = 1'b0;
            end
            eng_init_prev = M_INIT_AXI_TXN;
        end
    end

    // Requesters drop valid the cycle after their grant unless told to hold.
    initial begin
        logic [NR-1:0] drop_pend;
        drop_pend = '0;
        forever begin
            @(negedge ACLK);
            for (int i = 0; i < NR; i++) if (drop_pend[i]) req_valid[i] = 1'b0;
            drop_pend = auto_drop ? req_ready : '0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, g0, w0;
        int c0 [NR];
        ARESET     = 1'b1;
        req_valid  = '0;
        M_TXN_DONE = 1'b0;
        M_ERROR    = 1'b0;
        for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
        repeat (3) @(negedge ACLK);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_init", 64'(M_INIT_AXI_TXN), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_addr", 64'(M_TXN_ADDR), 64'(0));
        ARESET = 1'b0;

        // Single request from requester 0, done 10 cycles after launch.
        r0 = rsp_seen;
        exp_gnt_q.push_back(0);
        exp_txn_q.push_back('{addr_tab[0], data_tab[0], strb_tab[0]});
        exp_rsp_q.push_back('{0, 1'b0});
        eng_delay = 10;
        @(negedge ACLK);
        req_valid[0] = 1'b1;
        wait_quiet("single", 100);
        chk("single_rsp_count", 64'(rsp_seen - r0), 64'(1));
        chk("addr_hold", 64'(M_TXN_ADDR), 64'(32'h4000_0000));

        // Minimum latency: done rises in the first WAIT cycle.
        exp_gnt_q.push_back(0);
        exp_txn_q.push_back('{addr_tab[0], data_tab[0], strb_tab[0]});
        exp_rsp_q.push_back('{0, 1'b0});
        eng_delay = 0;
        lat_chk   = 1'b1;
        @(negedge ACLK);
        req_valid[0] = 1'b1;
        t0 = cyc;
        wait_quiet("latency", 50);
        lat_chk = 1'b0;

        // Reset while in WAIT abandons the transaction silently.
        eng_auto = 1'b0;
        r0 = rsp_seen;
        w0 = wait_seen;
        exp_gnt_q.push_back(2);
        exp_txn_q.push_back('{addr_tab[2], data_tab[2], strb_tab[2]});
        @(negedge ACLK);
        req_valid[2] = 1'b1;
        wait_for_wait("rst_wait_entry", w0);
        repeat (2) @(negedge ACLK);
        #2 ARESET = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_init", 64'(M_INIT_AXI_TXN), 64'(0));
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("arst_addr", 64'(M_TXN_ADDR), 64'(0));
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("arst_no_rsp", 64'(rsp_seen - r0), 64'(0));
        eng_auto = 1'b1;

        // Contention with all valids held: pointer restarts at 0 after reset.
        for (int i = 0; i < NR; i++) c0[i] = rsp_cnt[i];
        g0 = gnt_seen;
        foreach (exp_gnt_q[i]) chk("gnt_q_stale", 64'(exp_gnt_q.size()), 64'(0));
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % NR;
            exp_gnt_q.push_back(e);
            exp_txn_q.push_back('{addr_tab[e], data_tab[e], strb_tab[e]});
            exp_rsp_q.push_back('{e, 1'b0});
        end
        eng_delay = 3;
        auto_drop = 1'b0;
        @(negedge ACLK);
        req_valid = '1;
        for (int k = 0; k < 300 && gnt_seen < g0 + 5; k++) @(negedge ACLK);
        req_valid = '0;
        chk("contention_grants", 64'(gnt_seen - g0), 64'(5));
        wait_quiet("contention", 200);
        auto_drop = 1'b1;
        for (int i = 0; i < NR; i++)
            chk($sformatf("rsp_cnt%0d", i), 64'(rsp_cnt[i] - c0[i]), 64'((i == 0) ? 2 : 1));

        // Engine error on a requester-2 transaction, then a clean one from requester 3.
        eng_err = 1'b1;
        exp_gnt_q.push_back(2);
        exp_txn_q.push_back('{addr_tab[2], data_tab[2], strb_tab[2]});
        exp_rsp_q.push_back('{2, 1'b1});
        @(negedge ACLK);
        req_valid[2] = 1'b1;
        wait_quiet("error", 100);
        eng_err = 1'b0;
        exp_gnt_q.push_back(3);
        exp_txn_q.push_back('{addr_tab[3], data_tab[3], strb_tab[3]});
        exp_rsp_q.push_back('{3, 1'b0});
        @(negedge ACLK);
        req_valid[3] = 1'b1;
        wait_quiet("after_error", 100);

        // Stale done: high before WAIT, must fall and rise again.
        eng_auto = 1'b0;
        w0 = wait_seen;
        exp_gnt_q.push_back(1);
        exp_txn_q.push_back('{addr_tab[1], data_tab[1], strb_tab[1]});
        @(negedge ACLK);
        M_TXN_DONE   = 1'b1;
        req_valid[1] = 1'b1;
        wait_for_wait("stale_wait_entry", w0);
        r0 = rsp_seen;
        repeat (5) @(negedge ACLK);
        chk("stale_no_rsp", 64'(rsp_seen - r0), 64'(0));
        chk("stale_busy", 64'(busy), 64'(1));
        M_TXN_DONE = 1'b0;
        @(negedge ACLK);
        exp_rsp_q.push_back('{1, 1'b0});
        M_TXN_DONE = 1'b1;
        @(negedge ACLK);
        M_TXN_DONE = 1'b0;
        wait_quiet("stale", 50);

        // Engine never completes.
        w0 = wait_seen;
        r0 = rsp_seen;
        exp_gnt_q.push_back(0);
        exp_txn_q.push_back('{addr_tab[0], data_tab[0], strb_tab[0]});
`ifdef BYTE_WRITER_ARB_TIMEOUT_EN
        exp_rsp_q.push_back('{0, 1'b1});
        tmo_chk = 1'b1;
        @(negedge ACLK);
        req_valid[0] = 1'b1;
        wait_quiet("timeout", 100);
        tmo_chk = 1'b0;
        chk("timeout_rsp_count", 64'(rsp_seen - r0), 64'(1));
`else
        @(negedge ACLK);
        req_valid[0] = 1'b1;
        wait_for_wait("hang_wait_entry", w0);
        repeat (40) @(negedge ACLK);
        chk("hang_busy", 64'(busy), 64'(1));
        chk("hang_no_rsp", 64'(rsp_seen - r0), 64'(0));
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
`endif
        eng_auto = 1'b1;
        repeat (3) @(negedge ACLK);

        chk("end_gnt_q", 64'(exp_gnt_q.size()), 64'(0));
        chk("end_txn_q", 64'(exp_txn_q.size()), 64'(0));
        chk("end_rsp_q", 64'(exp_rsp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
